// File: rtl/inner_product_pkg.sv
// rtl/inner_product_pkg.sv - shared types and helpers for the inner-product MAC
//
// Purpose: FSM state encoding, accumulator width helper and the
//          saturate/truncate output conversion used by inner_product_mac.
package inner_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest accumulator that sat_trunc can handle.
  localparam int MAX_ACC_W = 64;

  // Full-precision accumulator width: one product is 2*i_width bits, summing
  // size of them needs $clog2(size) growth bits plus a sign guard bit.
  function automatic int acc_width(input int i_width, input int size);
    return 2 * i_width + $clog2(size) + 1;
  endfunction

  // Converts a sign-extended accumulator to the output range. The caller keeps
  // the low o_width bits of the result: with saturate set the value has been
  // clamped into range first, otherwise the low bits are a plain wrap.
  function automatic logic signed [63:0] sat_trunc(
    input logic signed [63:0] acc,
    input int                 o_width,
    input logic               saturate
  );
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (o_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (o_width - 1));
    if (saturate && (acc > max_v)) begin
      return max_v;
    end
    if (saturate && (acc < min_v)) begin
      return min_v;
    end
    return acc;
  endfunction

endpackage

// File: rtl/inner_product_slice.sv
// rtl/inner_product_slice.sv - PAR-wide signed multiply and sum, combinational
//
// Purpose: one beat worth of products for inner_product_mac.
// Ports:
//   vec_data  in   PAR*I_WIDTH   element j at [I_WIDTH*j +: I_WIDTH], signed
//   w_data    in   PAR*I_WIDTH   weight j at  [I_WIDTH*j +: I_WIDTH], signed
//   psum      out  2*I_WIDTH+$clog2(PAR)+1  signed sum of the PAR products
module inner_product_slice
  import inner_product_pkg::*;
#(
  parameter int PAR     = 5,
  parameter int I_WIDTH = 8
) (
  input  logic        [PAR*I_WIDTH-1:0]          vec_data,
  input  logic        [PAR*I_WIDTH-1:0]          w_data,
  output logic signed [2*I_WIDTH+$clog2(PAR):0]  psum
);

  localparam int PSUM_W = 2 * I_WIDTH + $clog2(PAR) + 1;

  always_comb begin
    logic signed [I_WIDTH-1:0]   a;
    logic signed [I_WIDTH-1:0]   b;
    logic signed [2*I_WIDTH-1:0] p;
    psum = '0;
    a    = '0;
    b    = '0;
    p    = '0;
    for (int j = 0; j < PAR; j++) begin
      a    = vec_data[j*I_WIDTH +: I_WIDTH];
      b    = w_data[j*I_WIDTH +: I_WIDTH];
      p    = a * b;
      psum = psum + PSUM_W'(p);
    end
  end

endmodule

// File: rtl/inner_product_mac.sv
// rtl/inner_product_mac.sv - handshaked, time-multiplexed signed dot product
//
// Purpose: dot product of a SIZE-element input vector with a loadable weight
//          vector, PAR products per cycle over SIZE/PAR beats.
// Ports:
//   clk, rst                  clock, async active-high reset
//   w_we, w_addr, w_data      weight write port (honoured in IDLE only)
//   in_valid/in_ready/in_data input vector handshake
//   out_valid/out_ready/out_data result handshake (out_data held until taken)
//   busy                      high while accumulating or holding a result
module inner_product_mac
  import inner_product_pkg::*;
#(
  parameter int SIZE     = 25,
  parameter int PAR      = 5,
  parameter int I_WIDTH  = 8,
  parameter int O_WIDTH  = 24,
  parameter int SATURATE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_we,
  input  logic [$clog2(SIZE)-1:0]    w_addr,
  input  logic [I_WIDTH-1:0]         w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [I_WIDTH*SIZE-1:0]    in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [O_WIDTH-1:0]         out_data,
  output logic                       busy
);

  localparam int BEATS  = SIZE / PAR;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_W  = acc_width(I_WIDTH, SIZE);
  localparam int PSUM_W = 2 * I_WIDTH + $clog2(PAR) + 1;

  generate
    if ((SIZE % PAR) != 0) begin : g_size_check
      $error("inner_product_mac: SIZE must be a multiple of PAR");
    end
    if (ACC_W > MAX_ACC_W) begin : g_width_check
      $error("inner_product_mac: accumulator wider than sat_trunc supports");
    end
  endgenerate

  state_t                      state;
  state_t                      state_nxt;
  logic [SIZE*I_WIDTH-1:0]     vec;
  logic [I_WIDTH-1:0]          w [SIZE];
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_nxt;
  logic [BEAT_W-1:0]           beat;
  logic [PAR*I_WIDTH-1:0]      vec_sel;
  logic [PAR*I_WIDTH-1:0]      w_sel;
  logic signed [PSUM_W-1:0]    psum;
  logic                        accept;
  logic                        last_beat;
  logic                        w_ok;

  // DONE passes out_ready straight through so a new vector can be taken in
  // the same cycle the held result is dequeued.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // Weights only change while nothing is in flight; a write colliding with
  // an input acceptance is dropped so the captured vector sees one weight set.
  assign w_ok = w_we && (state == IDLE) && !in_valid && (int'(w_addr) < SIZE);

  // Select this beat's elements and weights for the single shared slice.
  always_comb begin
    vec_sel = '0;
    w_sel   = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        vec_sel = vec[b*PAR*I_WIDTH +: PAR*I_WIDTH];
        for (int j = 0; j < PAR; j++) begin
          w_sel[j*I_WIDTH +: I_WIDTH] = w[b*PAR+j];
        end
      end
    end
  end

  inner_product_slice #(
    .PAR     (PAR),
    .I_WIDTH (I_WIDTH)
  ) u_slice (
    .vec_data (vec_sel),
    .w_data   (w_sel),
    .psum     (psum)
  );

  assign acc_nxt = acc + ACC_W'(psum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = in_valid ? ACCUM : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      acc      <= '0;
      beat     <= '0;
      out_data <= '0;
      for (int i = 0; i < SIZE; i++) begin
        w[i] <= '0;
      end
    end else begin
      if (w_ok) begin
        w[w_addr] <= w_data;
      end
      if (accept) begin
        vec  <= in_data;
        acc  <= '0;
        beat <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_nxt;
        if (last_beat) begin
          beat     <= '0;
          out_data <= O_WIDTH'(sat_trunc(64'(acc_nxt), O_WIDTH, SATURATE != 0));
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inner_product_mac.sv
// tb/tb_inner_product_mac.sv - self-checking bench for inner_product_mac
module tb_inner_product_mac;

  typedef struct {
    logic [31:0] w;
    logic [31:0] x;
    int          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: SIZE=4, PAR=2, O_WIDTH=24, saturating.
  logic               a_w_we = 1'b0;
  logic [1:0]         a_w_addr = '0;
  logic [7:0]         a_w_data = '0;
  logic               a_in_valid = 1'b0;
  logic               a_in_ready;
  logic [31:0]        a_in_data = '0;
  logic               a_out_valid;
  logic               a_out_ready = 1'b0;
  logic signed [23:0] a_out_data;
  logic               a_busy;

  // Two large instances sharing stimulus: SIZE=25, PAR=5, O_WIDTH=16.
  logic               b_w_we = 1'b0;
  logic [4:0]         b_w_addr = '0;
  logic [7:0]         b_w_data = '0;
  logic               b_in_valid = 1'b0;
  logic [199:0]       b_in_data = '0;
  logic               b_out_ready = 1'b0;
  logic               s_in_ready, s_out_valid, s_busy;
  logic signed [15:0] s_out_data;
  logic               t_in_ready, t_out_valid, t_busy;
  logic signed [15:0] t_out_data;

  inner_product_mac #(.SIZE(4), .PAR(2), .I_WIDTH(8), .O_WIDTH(24), .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .w_we(a_w_we), .w_addr(a_w_addr), .w_data(a_w_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  inner_product_mac #(.SIZE(25), .PAR(5), .I_WIDTH(8), .O_WIDTH(16), .SATURATE(1)) u_s (
    .clk(clk), .rst(rst), .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data),
    .in_valid(b_in_valid), .in_ready(s_in_ready), .in_data(b_in_data),
    .out_valid(s_out_valid), .out_ready(b_out_ready), .out_data(s_out_data), .busy(s_busy)
  );

  inner_product_mac #(.SIZE(25), .PAR(5), .I_WIDTH(8), .O_WIDTH(16), .SATURATE(0)) u_t (
    .clk(clk), .rst(rst), .w_we(b_w_we), .w_addr(b_w_addr), .w_data(b_w_data),
    .in_valid(b_in_valid), .in_ready(t_in_ready), .in_data(b_in_data),
    .out_valid(t_out_valid), .out_ready(b_out_ready), .out_data(t_out_data), .busy(t_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(e0); b1 = 8'(e1); b2 = 8'(e2); b3 = 8'(e3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic write_w_a(input int addr, input int data);
    a_w_we = 1'b1; a_w_addr = 2'(addr); a_w_data = 8'(data);
    tick();
    a_w_we = 1'b0;
  endtask

  task automatic load_w_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) write_w_a(i, int'($signed(w[i*8 +: 8])));
  endtask

  // Present a vector, wait for the result with a bound, check latency and
  // value, then dequeue it.
  task automatic run_a(input logic [31:0] x, input int exp, input string name);
    int cyc;
    a_in_data = x; a_in_valid = 1'b1;
    #1;
    check({name, " in_ready"}, int'(a_in_ready), 1);
    tick();
    a_in_valid = 1'b0; a_w_we = 1'b0;
    cyc = 0;
    while (!a_out_valid && cyc < 20) begin
      check({name, " busy"}, int'(a_busy), 1);
      tick();
      cyc++;
    end
    check({name, " latency"}, cyc, 2);
    check({name, " data"}, int'(a_out_data), exp);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check({name, " drained"}, int'(a_out_valid), 0);
  endtask

  task automatic load_w_b(input int v);
    for (int i = 0; i < 25; i++) begin
      b_w_we = 1'b1; b_w_addr = 5'(i); b_w_data = 8'(v);
      tick();
    end
    b_w_we = 1'b0;
  endtask

  task automatic run_b(input int xv, input int exp_s, input int exp_t, input string name);
    int cyc;
    for (int i = 0; i < 25; i++) b_in_data[i*8 +: 8] = 8'(xv);
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    cyc = 0;
    while (!s_out_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    check({name, " latency"}, cyc, 5);
    check({name, " sat data"}, int'(s_out_data), exp_s);
    check({name, " wrap valid"}, int'(t_out_valid), 1);
    check({name, " wrap data"}, int'(t_out_data), exp_t);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    int cyc;
    tbl[0] = '{w: pack4(1, 1, 1, 1),         x: pack4(1, 2, 3, 4),        exp: 10};
    tbl[1] = '{w: pack4(2, -1, 0, 3),        x: pack4(5, 5, 5, 5),        exp: 20};
    tbl[2] = '{w: pack4(-128, -128, -128, -128), x: pack4(-128, -128, -128, -128), exp: 65536};
    tbl[3] = '{w: pack4(127, 127, 127, 127), x: pack4(-128, -128, -128, -128), exp: -65024};
    tbl[4] = '{w: pack4(1, -1, 1, -1),       x: pack4(100, 50, -20, 7),   exp: 23};
    tbl[5] = '{w: pack4(3, 0, -2, 5),        x: pack4(-7, 9, 11, -1),     exp: -48};

    // Reset state
    #2;
    check("rst out_valid", int'(a_out_valid), 0);
    check("rst in_ready", int'(a_in_ready), 1);
    check("rst busy", int'(a_busy), 0);
    check("rst out_data", int'(a_out_data), 0);
    tick();
    rst = 1'b0;
    tick();

    // Table of vectors through the small instance
    for (int i = 0; i < 6; i++) begin
      load_w_a(tbl[i].w);
      run_a(tbl[i].x, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure, then back-to-back acceptance while dequeuing
    load_w_a(pack4(2, -1, 0, 3));
    a_in_data = pack4(1, 2, 3, 4); a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    cyc = 0;
    while (!a_out_valid && cyc < 20) begin tick(); cyc++; end
    check("bp latency", cyc, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp hold data", int'(a_out_data), 12);
      check("bp hold valid", int'(a_out_valid), 1);
      check("bp in_ready", int'(a_in_ready), 0);
    end
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = pack4(5, 5, 5, 5);
    #1;
    check("b2b in_ready", int'(a_in_ready), 1);
    tick();
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    check("b2b accum", int'(a_out_valid), 0);
    check("b2b busy", int'(a_busy), 1);
    cyc = 0;
    while (!a_out_valid && cyc < 20) begin tick(); cyc++; end
    check("b2b latency", cyc, 2);
    check("b2b data", int'(a_out_data), 20);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // Weight writes during ACCUM and DONE are ignored
    load_w_a(pack4(1, 1, 1, 1));
    a_in_data = pack4(1, 2, 3, 4); a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_w_we = 1'b1; a_w_addr = 2'd0; a_w_data = 8'd7;
    tick(); tick(); tick();
    a_w_we = 1'b0;
    check("wprot held", int'(a_out_data), 10);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    run_a(pack4(1, 2, 3, 4), 10, "wprot after");
    write_w_a(0, 7);
    run_a(pack4(1, 2, 3, 4), 16, "widle write");
    // Write colliding with input acceptance is dropped
    a_w_we = 1'b1; a_w_addr = 2'd0; a_w_data = 8'd1;
    run_a(pack4(1, 2, 3, 4), 16, "wcollide");
    run_a(pack4(1, 2, 3, 4), 16, "wcollide after");

    // Large instances: saturation and wrap, both signs
    load_w_b(-128);
    run_b(-128, 32767, 16384, "big pos");
    load_w_b(127);
    run_b(-128, -32768, -13184, "big neg");
    b_w_we = 1'b1; b_w_addr = 5'd30; b_w_data = 8'd0;
    tick();
    b_w_we = 1'b0;
    run_b(-128, -32768, -13184, "big oob addr");

    // Reset in the middle of accumulation
    a_in_data = pack4(1, 2, 3, 4); a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid rst out_valid", int'(a_out_valid), 0);
    check("mid rst in_ready", int'(a_in_ready), 1);
    check("mid rst busy", int'(a_busy), 0);
    check("mid rst out_data", int'(a_out_data), 0);
    tick();
    rst = 1'b0;
    tick();
    run_a(pack4(1, 2, 3, 4), 0, "post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
